// File: rtl/tick_stopwatch.sv
// Stopwatch on the basys_clk domain: edge-detects the slow divided clock, prescales
// it to 0.1 s steps and keeps M:SS.t BCD time under start/stop/clear control.
module tick_stopwatch #(
    parameter int unsigned TICKS_PER_STEP = 2,
    parameter int unsigned MAX_MIN        = 9
) (
    input  logic       basys_clk,
    input  logic       reset,
    input  logic       slow_clk,
    input  logic       start_stop,
    input  logic       clear,
    output logic [3:0] digit_tenth,
    output logic [3:0] digit_sec_o,
    output logic [3:0] digit_sec_t,
    output logic [3:0] digit_min,
    output logic       running,
    output logic       step_pulse,
    output logic       overflow
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_PAUSE = 2'd2;

    localparam logic [3:0] LAST_TICK = 4'(TICKS_PER_STEP - 1);
    localparam logic [3:0] MIN_TOP   = 4'(MAX_MIN);

    logic [1:0] state;
    logic [1:0] state_nxt;
    logic [3:0] prescaler;
    logic       slow_d;
    logic       tick;
    logic       advance;
    logic       step;

    assign tick    = slow_clk & ~slow_d;
    // Ticks count only in RUN as held before this edge, so the tick that
    // coincides with the entering start_stop is ignored.
    assign advance = tick && (state == ST_RUN) && !clear;
    assign step    = advance && (prescaler == LAST_TICK);

    always_comb begin
        // NOTE: default first so every path assigns state_nxt; otherwise a latch is inferred.
        state_nxt = state;
        if (clear) begin
            state_nxt = ST_IDLE;
        end else if (start_stop) begin
            case (state)
                ST_IDLE:  state_nxt = ST_RUN;
                ST_RUN:   state_nxt = ST_PAUSE;
                ST_PAUSE: state_nxt = ST_RUN;
                default:  state_nxt = ST_IDLE;
            endcase
        end
    end

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge basys_clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            running     <= 1'b0;
            step_pulse  <= 1'b0;
            overflow    <= 1'b0;
            prescaler   <= 4'd0;
            slow_d      <= 1'b1;
            digit_tenth <= 4'd0;
            digit_sec_o <= 4'd0;
            digit_sec_t <= 4'd0;
            digit_min   <= 4'd0;
        end else begin
            slow_d     <= slow_clk;
            state      <= state_nxt;
            running    <= (state_nxt == ST_RUN);
            step_pulse <= step;

            if (clear) begin
                prescaler   <= 4'd0;
                overflow    <= 1'b0;
                digit_tenth <= 4'd0;
                digit_sec_o <= 4'd0;
                digit_sec_t <= 4'd0;
                digit_min   <= 4'd0;
            end else if (advance) begin
                prescaler <= step ? 4'd0 : prescaler + 4'd1;
                // Whole carry chain resolves in one edge; no partial carry is ever visible.
                if (step) begin
                    if (digit_tenth != 4'd9) begin
                        digit_tenth <= digit_tenth + 4'd1;
                    end else begin
                        digit_tenth <= 4'd0;
                        if (digit_sec_o != 4'd9) begin
                            digit_sec_o <= digit_sec_o + 4'd1;
                        end else begin
                            digit_sec_o <= 4'd0;
                            if (digit_sec_t != 4'd5) begin
                                digit_sec_t <= digit_sec_t + 4'd1;
                            end else begin
                                digit_sec_t <= 4'd0;
                                if (digit_min != MIN_TOP) begin
                                    digit_min <= digit_min + 4'd1;
                                end else begin
                                    digit_min <= 4'd0;
                                    overflow  <= 1'b1;
                                end
                            end
                        end
                    end
                end
            end
        end
    end

endmodule
